// File: rtl/sync_fifo_fwft.sv
// Parametrised single-clock first-word-fall-through FIFO with reset-busy handshake,
// occupancy count and programmable full. Define SYNC_FIFO_ERR_FLAGS_EN to add overflow/underflow pulses.
module sync_fifo_fwft #(
    parameter int WIDTH            = 512,
    parameter int DEPTH_LOG2       = 9,
    parameter int PROG_FULL_THRESH = 496,
    parameter int RST_BUSY_CYCLES  = 4
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic [WIDTH-1:0]      din,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  prog_full,
    output logic                  wr_rst_busy,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      dout,
    output logic                  valid,
    output logic                  empty,
    output logic                  rd_rst_busy,
    output logic [DEPTH_LOG2:0]   data_count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int CNT_W  = DEPTH_LOG2 + 1;
    localparam int BUSY_W = $clog2(RST_BUSY_CYCLES + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  THRESH_C    = CNT_W'(PROG_FULL_THRESH);
    localparam logic [BUSY_W-1:0] BUSY_INIT_C = BUSY_W'(RST_BUSY_CYCLES);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [WIDTH-1:0]      mem_rd_q;
    logic                  mem_vld_q, mem_vld_d;
    logic [WIDTH-1:0]      dout_q, dout_d;
    logic                  valid_q, valid_d;
    logic                  empty_q, empty_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full_q, full_d;
    logic                  prog_full_q, prog_full_d;
    logic                  busy_q, busy_d;
    logic [BUSY_W-1:0]     busy_cnt_q, busy_cnt_d;

    logic                  wr_acc_s, rd_acc_s;
    logic                  out_free_s, s1_to_out_s, mem_load_s;
    logic [CNT_W-1:0]      mem_words_s;

    // Handshake qualification and prefetch pipeline control
    always_comb begin
        wr_acc_s    = wr_en & ~full_q & ~busy_q;
        rd_acc_s    = rd_en & valid_q & ~busy_q;
        // Words still parked in memory: total minus those held in the two prefetch stages
        mem_words_s = count_q - CNT_W'(mem_vld_q) - CNT_W'(valid_q);
        out_free_s  = ~valid_q | rd_acc_s;
        s1_to_out_s = mem_vld_q & out_free_s;
        mem_load_s  = (mem_words_s != {CNT_W{1'b0}}) & (~mem_vld_q | s1_to_out_s);
    end

    // Next-state for pointers, stages, count, flags and reset-busy counter
    always_comb begin
        wr_ptr_d    = wr_ptr_q + DEPTH_LOG2'(wr_acc_s);
        rd_ptr_d    = rd_ptr_q + DEPTH_LOG2'(mem_load_s);
        dout_d      = dout_q;
        valid_d     = valid_q;
        mem_vld_d   = mem_vld_q;
        count_d     = count_q;
        busy_d      = busy_q;
        busy_cnt_d  = busy_cnt_q;

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (s1_to_out_s) begin
            valid_d = 1'b1;
            dout_d  = mem_rd_q;
        end else if (rd_acc_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        if (mem_load_s) begin
            mem_vld_d = 1'b1;
        end else if (s1_to_out_s) begin
            mem_vld_d = 1'b0;
        end else begin
            mem_vld_d = mem_vld_q;
        end

        // Busy holds for RST_BUSY_CYCLES edges after srst goes low, dropping on the next one
        if (busy_cnt_q != {BUSY_W{1'b0}}) begin
            busy_cnt_d = busy_cnt_q - BUSY_W'(1);
            busy_d     = 1'b1;
        end else begin
            busy_cnt_d = busy_cnt_q;
            busy_d     = 1'b0;
        end

        empty_d     = ~valid_d;
        full_d      = busy_d | (count_d == DEPTH_C);
        prog_full_d = (count_d >= THRESH_C);
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q    <= {DEPTH_LOG2{1'b0}};
            rd_ptr_q    <= {DEPTH_LOG2{1'b0}};
            dout_q      <= {WIDTH{1'b0}};
            valid_q     <= 1'b0;
            empty_q     <= 1'b1;
            mem_vld_q   <= 1'b0;
            count_q     <= {CNT_W{1'b0}};
            full_q      <= 1'b1;
            prog_full_q <= 1'b0;
            busy_q      <= 1'b1;
            busy_cnt_q  <= BUSY_INIT_C;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            dout_q      <= dout_d;
            valid_q     <= valid_d;
            empty_q     <= empty_d;
            mem_vld_q   <= mem_vld_d;
            count_q     <= count_d;
            full_q      <= full_d;
            prog_full_q <= prog_full_d;
            busy_q      <= busy_d;
            busy_cnt_q  <= busy_cnt_d;
        end
    end

    // Storage array write port, kept free of reset so it maps onto block memory
    always_ff @(posedge clk) begin
        if (wr_acc_s & ~srst) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Memory read register: first prefetch stage
    always_ff @(posedge clk) begin
        if (srst) begin
            mem_rd_q <= {WIDTH{1'b0}};
        end else if (mem_load_s) begin
            mem_rd_q <= mem_q[rd_ptr_q];
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Refused requests, reported one cycle later
    always_comb begin
        overflow_d  = wr_en & ~wr_acc_s;
        underflow_d = rd_en & ~rd_acc_s;
    end

    // Error pulse registers
    always_ff @(posedge clk) begin
        if (srst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

    assign full        = full_q;
    assign prog_full   = prog_full_q;
    assign wr_rst_busy = busy_q;
    assign rd_rst_busy = busy_q;
    assign dout        = dout_q;
    assign valid       = valid_q;
    assign empty       = empty_q;
    assign data_count  = count_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Scoreboard bench for sync_fifo_fwft at DEPTH=16, threshold 12, four busy cycles.
module tb_sync_fifo_fwft;

    localparam int WIDTH  = 16;
    localparam int DL2    = 4;
    localparam int DEPTH  = 16;
    localparam int THRESH = 12;
    localparam int BUSY   = 4;
    localparam int CW     = DL2 + 1;

    logic             clk = 1'b0;
    logic             srst;
    logic [WIDTH-1:0] din;
    logic             wr_en;
    logic             full;
    logic             prog_full;
    logic             wr_rst_busy;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             valid;
    logic             empty;
    logic             rd_rst_busy;
    logic [CW-1:0]    data_count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic             overflow;
    logic             underflow;
`endif

    int errors = 0;
    int checks = 0;
    logic [WIDTH-1:0] sb[$];
    int m_count  = 0;
    int m_left   = 0;
    int n_wr_acc = 0;
    bit m_busy   = 1'b1;

    always #5 clk = ~clk;

    sync_fifo_fwft #(
        .WIDTH(WIDTH), .DEPTH_LOG2(DL2), .PROG_FULL_THRESH(THRESH), .RST_BUSY_CYCLES(BUSY)
    ) dut (
        .clk(clk), .srst(srst), .din(din), .wr_en(wr_en), .full(full),
        .prog_full(prog_full), .wr_rst_busy(wr_rst_busy), .rd_en(rd_en),
        .dout(dout), .valid(valid), .empty(empty), .rd_rst_busy(rd_rst_busy),
        .data_count(data_count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        , .overflow(overflow), .underflow(underflow)
`endif
    );

    // One clock of stimulus; pops the scoreboard when the DUT hands over a word
    task automatic cycle(input bit w, input logic [WIDTH-1:0] d, input bit r);
        bit wacc;
        bit racc;
        logic [WIDTH-1:0] exp_w;
        wr_en = w;
        din   = d;
        rd_en = r;
        wacc  = w && (m_count < DEPTH) && !m_busy;
        racc  = r && (valid === 1'b1) && !m_busy;
        if (racc) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_underrun: dout=%h offered with nothing expected", dout);
            end else begin
                exp_w = sb.pop_front();
                if (dout !== exp_w) begin
                    errors++;
                    $display("FAIL sb_data: got %h expected %h", dout, exp_w);
                end
            end
        end
        if (wacc) begin
            sb.push_back(d);
            n_wr_acc++;
        end
        @(posedge clk);
        #1;
        if (wacc && !racc) m_count++;
        else if (!wacc && racc) m_count--;
        if (m_left > 0) begin
            m_left--;
            m_busy = 1'b1;
        end else begin
            m_busy = 1'b0;
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (m_count > 0 && n < 60) begin
            cycle(1'b0, '0, 1'b1);
            n++;
        end
        checks++;
        if (m_count != 0 || sb.size() != 0 || data_count !== '0) begin
            errors++;
            $display("FAIL %s_drain: data_count=%0d model=%0d left=%0d expected all 0", tag, data_count, m_count, sb.size());
        end
    endtask

    task automatic test_reset();
        srst  = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({full, prog_full, valid, empty, wr_rst_busy, rd_rst_busy} !== 6'b100111) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 100111",
                     {full, prog_full, valid, empty, wr_rst_busy, rd_rst_busy});
        end
        checks++;
        if (dout !== 16'h0000 || data_count !== 5'd0) begin
            errors++;
            $display("FAIL reset_data: dout=%h count=%0d expected 0/0", dout, data_count);
        end
        srst = 1'b0;
        m_count = 0; sb.delete(); m_busy = 1'b1; m_left = BUSY;
        for (int i = 0; i < BUSY; i++) begin
            cycle(i == 1, 16'h0BAD, i == 2);
            checks++;
            if ({wr_rst_busy, rd_rst_busy, full} !== 3'b111 || data_count !== 5'd0) begin
                errors++;
                $display("FAIL busy_hold_%0d: busy/busy/full=%b count=%0d expected 111 and 0",
                         i, {wr_rst_busy, rd_rst_busy, full}, data_count);
            end
        end
        cycle(1'b0, '0, 1'b0);
        checks++;
        if ({wr_rst_busy, rd_rst_busy, full} !== 3'b000) begin
            errors++;
            $display("FAIL busy_release: got %b expected 000", {wr_rst_busy, rd_rst_busy, full});
        end
    endtask

    task automatic test_latency();
        cycle(1'b1, 16'h00A5, 1'b0);
        checks++;
        if (valid !== 1'b0 || data_count !== 5'd1) begin
            errors++;
            $display("FAIL lat_k: valid=%b count=%0d expected 0/1", valid, data_count);
        end
        cycle(1'b0, '0, 1'b0);
        checks++;
        if (valid !== 1'b0 || data_count !== 5'd1) begin
            errors++;
            $display("FAIL lat_gap: valid=%b count=%0d expected 0/1", valid, data_count);
        end
        cycle(1'b0, '0, 1'b0);
        checks++;
        if (valid !== 1'b1 || dout !== 16'h00A5 || empty !== 1'b0) begin
            errors++;
            $display("FAIL lat_k2: valid=%b dout=%h empty=%b expected 1/00a5/0", valid, dout, empty);
        end
        cycle(1'b0, '0, 1'b1);
        checks++;
        if (valid !== 1'b0 || empty !== 1'b1 || data_count !== 5'd0) begin
            errors++;
            $display("FAIL lat_pop: valid=%b empty=%b count=%0d expected 0/1/0", valid, empty, data_count);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, WIDTH'(16'h0100 + i), 1'b0);
            checks++;
            if ({data_count, prog_full, full} !== {CW'(i + 1), (i + 1 >= THRESH), (i + 1 == DEPTH)}) begin
                errors++;
                $display("FAIL fill_%0d: count/pf/full=%0d/%b/%b expected %0d/%b/%b", i, data_count,
                         prog_full, full, i + 1, (i + 1 >= THRESH), (i + 1 == DEPTH));
            end
        end
        cycle(1'b1, 16'hDEAD, 1'b0);
        checks++;
        if (data_count !== 5'd16 || full !== 1'b1) begin
            errors++;
            $display("FAIL fill_overrun: count=%0d full=%b expected 16/1", data_count, full);
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_pulse: got %b expected 1", overflow);
        end
`endif
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (valid !== 1'b1) begin
                errors++;
                $display("FAIL drain_gap_%0d: valid=%b expected 1", i, valid);
            end
            cycle(1'b0, '0, 1'b1);
            checks++;
            if ({data_count, prog_full} !== {CW'(DEPTH - i - 1), (DEPTH - i - 1 >= THRESH)}) begin
                errors++;
                $display("FAIL drain_cnt_%0d: count/pf=%0d/%b expected %0d/%b", i, data_count,
                         prog_full, DEPTH - i - 1, (DEPTH - i - 1 >= THRESH));
            end
        end
        checks++;
        if (valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL drain_end: valid=%b left=%0d expected 0/0", valid, sb.size());
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        cycle(1'b0, '0, 1'b1);
        checks++;
        if (underflow !== 1'b1) begin
            errors++;
            $display("FAIL underflow_pulse: got %b expected 1", underflow);
        end
`endif
    endtask

    task automatic test_boundary();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, WIDTH'(16'h0200 + i), 1'b0);
        checks++;
        if (full !== 1'b1) begin
            errors++;
            $display("FAIL bnd_full: got %b expected 1", full);
        end
        cycle(1'b1, 16'hBEEF, 1'b1);
        checks++;
        if (data_count !== 5'd15 || full !== 1'b0) begin
            errors++;
            $display("FAIL bnd_full_rw: count=%0d full=%b expected 15/0", data_count, full);
        end
        for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 16'h0300, 1'b1);
        checks++;
        if (data_count !== 5'd8) begin
            errors++;
            $display("FAIL bnd_mid_rw: count=%0d expected 8", data_count);
        end
        drain("bnd_mid");
        cycle(1'b1, 16'h0400, 1'b1);
        checks++;
        if (data_count !== 5'd1 || valid !== 1'b0) begin
            errors++;
            $display("FAIL bnd_empty_rw: count=%0d valid=%b expected 1/0", data_count, valid);
        end
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        checks++;
        if (valid !== 1'b1 || dout !== 16'h0400) begin
            errors++;
            $display("FAIL bnd_empty_lat: valid=%b dout=%h expected 1/0400", valid, dout);
        end
        drain("bnd_empty");
    endtask

    task automatic test_streaming();
        int start_wr;
        start_wr = n_wr_acc;
        for (int i = 0; i < 1000; i++) begin
            cycle(1'b1, WIDTH'($urandom), 1'b1);
            checks++;
            if (data_count !== CW'(m_count) || m_count > DEPTH) begin
                errors++;
                $display("FAIL stream_cnt_%0d: count=%0d expected %0d", i, data_count, m_count);
            end
        end
        checks++;
        if (n_wr_acc - start_wr <= 50 * DEPTH) begin
            errors++;
            $display("FAIL stream_wraps: accepted %0d writes, required more than %0d", n_wr_acc - start_wr, 50 * DEPTH);
        end
        drain("stream");
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, WIDTH'(16'h0500 + i), 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        checks++;
        if (valid !== 1'b1 || data_count !== 5'd10) begin
            errors++;
            $display("FAIL mrst_pre: valid=%b count=%0d expected 1/10", valid, data_count);
        end
        srst = 1'b1;
        @(posedge clk);
        #1;
        srst = 1'b0;
        m_count = 0; sb.delete(); m_busy = 1'b1; m_left = BUSY;
        checks++;
        if (valid !== 1'b0 || data_count !== 5'd0 || wr_rst_busy !== 1'b1 || rd_rst_busy !== 1'b1) begin
            errors++;
            $display("FAIL mrst_flush: valid=%b count=%0d busy=%b%b expected 0/0/11",
                     valid, data_count, wr_rst_busy, rd_rst_busy);
        end
        for (int i = 0; i < BUSY; i++) cycle(1'b1, 16'h0777, 1'b1);
        checks++;
        if (data_count !== 5'd0 || wr_rst_busy !== 1'b1) begin
            errors++;
            $display("FAIL mrst_busy_ignore: count=%0d busy=%b expected 0/1", data_count, wr_rst_busy);
        end
        cycle(1'b0, '0, 1'b0);
        cycle(1'b1, 16'h0600, 1'b0);
        cycle(1'b1, 16'h0601, 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        checks++;
        if (valid !== 1'b1 || dout !== 16'h0600) begin
            errors++;
            $display("FAIL mrst_first: valid=%b dout=%h expected 1/0600", valid, dout);
        end
        drain("mrst");
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill();
        test_boundary();
        test_streaming();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
